// File: rtl/fp_addsub_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp_addsub_pkg
// Brief    : Shared states, constants and field helpers for the sequenced
//            single-precision add/subtract unit.
// Revision : 1.0
// ============================================================================
package fp_addsub_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CHECK   = 3'd1,
        COMPARE = 3'd2,
        ALIGN   = 3'd3,
        ADD     = 3'd4,
        NORM    = 3'd5,
        ROUND   = 3'd6,
        DONE    = 3'd7
    } state_t;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [7:0]  EXP_MAX = 8'hFF;
    // {carry, hidden, 23 fraction, guard, round, sticky}
    localparam int          MANT_W  = 28;

    // Denormals are not supported: a zero exponent collapses to signed zero.
    function automatic logic [31:0] flush_zero(input logic [31:0] f);
        return (f[30:23] == 8'd0) ? {f[31], 31'd0} : f;
    endfunction

    function automatic logic is_nan(input logic [31:0] f);
        return (f[30:23] == EXP_MAX) && (f[22:0] != 23'd0);
    endfunction

    function automatic logic is_inf(input logic [31:0] f);
        return (f[30:23] == EXP_MAX) && (f[22:0] == 23'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_round_rne.sv
`default_nettype none
// ============================================================================
// Module   : fp_round_rne
// Brief    : Round-to-nearest-even and IEEE-754 packing of a normalized
//            {hidden, fraction, G, R, S} mantissa.
// Revision : 1.0
// ============================================================================
module fp_round_rne
    import fp_addsub_pkg::*;
(
    input  logic              sign,
    input  logic [7:0]        expo,
    input  logic [MANT_W-2:0] mant,
    output logic [31:0]       result
);

    logic        w_inc;
    logic [24:0] w_sig;
    logic [8:0]  w_exp;
    logic [22:0] w_frac;

    assign w_inc  = mant[2] & (mant[1] | mant[0] | mant[3]);
    assign w_sig  = {1'b0, mant[26:3]} + {24'd0, w_inc};
    // Rounding out of the top bit leaves a power of two: drop one bit, bump exponent.
    assign w_exp  = {1'b0, expo} + {8'd0, w_sig[24]};
    assign w_frac = w_sig[24] ? w_sig[23:1] : w_sig[22:0];

    assign result = (w_exp >= {1'b0, EXP_MAX}) ? {sign, EXP_MAX, 23'd0}
                                               : {sign, w_exp[7:0], w_frac};

endmodule
`default_nettype wire

// File: rtl/fp_addsub_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fp_addsub_sequencer
// Brief    : Multi-cycle IEEE-754 single-precision add/subtract with
//            valid/ready request and result ports.
// Revision : 1.0
// ============================================================================
module fp_addsub_sequencer
    import fp_addsub_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MENT_WIDTH = 23,
    parameter int EXPO_WIDTH = 8,
    parameter int MAX_ALIGN  = 26
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  in_valid_in,
    output logic                  in_ready_out,
    input  logic [DATA_WIDTH-1:0] floating1_in,
    input  logic [DATA_WIDTH-1:0] floating2_in,
    input  logic                  opcode_in,
    output logic                  out_valid_out,
    input  logic                  out_ready_in,
    output logic [DATA_WIDTH-1:0] result_out,
    output logic                  busy_out
);

    localparam int                    SIGN_BIT  = DATA_WIDTH - 1;
    localparam int                    EXP_LSB   = MENT_WIDTH;
    localparam int                    EXP_MSB   = MENT_WIDTH + EXPO_WIDTH - 1;
    localparam int                    MW        = MANT_W - 1;
    localparam logic [EXPO_WIDTH-1:0] ALIGN_CAP = EXPO_WIDTH'(MAX_ALIGN + 1);
    localparam logic [EXPO_WIDTH-1:0] EXP_ONE   = EXPO_WIDTH'(1);

    state_t                  r_state;
    logic                    r_in_ready;
    logic                    r_out_valid;
    logic [DATA_WIDTH-1:0]   r_result;
    logic [DATA_WIDTH-1:0]   r_op_a;
    logic [DATA_WIDTH-1:0]   r_op_b;
    logic                    r_sign;
    logic                    r_eff_sub;
    logic [EXPO_WIDTH-1:0]   r_exp;
    logic [EXPO_WIDTH-1:0]   r_shift_cnt;
    logic [MW-1:0]           r_ma;
    logic [MW-1:0]           r_mb;
    logic [MANT_W-1:0]       r_sum;

    logic [DATA_WIDTH-1:0]   w_fa;
    logic [DATA_WIDTH-1:0]   w_fb;
    logic                    w_inf_a;
    logic                    w_inf_b;
    logic                    w_nan_res;
    logic                    w_swap;
    logic [DATA_WIDTH-1:0]   w_big;
    logic [DATA_WIDTH-1:0]   w_small;
    logic [EXPO_WIDTH-1:0]   w_diff;
    logic [MW-1:0]           w_big_m;
    logic [MW-1:0]           w_small_m;
    logic [DATA_WIDTH-1:0]   w_rounded;

    assign w_fa      = flush_zero(r_op_a);
    assign w_fb      = flush_zero(r_op_b);
    assign w_inf_a   = is_inf(w_fa);
    assign w_inf_b   = is_inf(w_fb);
    assign w_nan_res = is_nan(w_fa) | is_nan(w_fb)
                     | (w_inf_a & w_inf_b & (w_fa[SIGN_BIT] ^ w_fb[SIGN_BIT]));

    // Exponent sits above the fraction, so one unsigned compare orders magnitudes.
    assign w_swap    = r_op_b[SIGN_BIT-1:0] > r_op_a[SIGN_BIT-1:0];
    assign w_big     = w_swap ? r_op_b : r_op_a;
    assign w_small   = w_swap ? r_op_a : r_op_b;
    assign w_diff    = w_big[EXP_MSB:EXP_LSB] - w_small[EXP_MSB:EXP_LSB];
    assign w_big_m   = {|w_big[EXP_MSB:EXP_LSB],   w_big[MENT_WIDTH-1:0],   3'b000};
    assign w_small_m = {|w_small[EXP_MSB:EXP_LSB], w_small[MENT_WIDTH-1:0], 3'b000};

    fp_round_rne u_round (
        .sign   (r_sign),
        .expo   (r_exp),
        .mant   (r_sum[MW-1:0]),
        .result (w_rounded)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_sign      <= 1'b0;
            r_eff_sub   <= 1'b0;
            r_exp       <= '0;
            r_shift_cnt <= '0;
            r_ma        <= '0;
            r_mb        <= '0;
            r_sum       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid_in && r_in_ready) begin
                        r_op_a     <= floating1_in;
                        r_op_b     <= {floating2_in[SIGN_BIT] ^ opcode_in,
                                       floating2_in[SIGN_BIT-1:0]};
                        r_in_ready <= 1'b0;
                        r_state    <= CHECK;
                    end
                end

                CHECK: begin
                    if (w_nan_res) begin
                        r_result    <= QNAN;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else if (w_inf_a) begin
                        r_result    <= w_fa;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else if (w_inf_b) begin
                        r_result    <= w_fb;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_op_a  <= w_fa;
                        r_op_b  <= w_fb;
                        r_state <= COMPARE;
                    end
                end

                COMPARE: begin
                    r_sign    <= w_big[SIGN_BIT];
                    r_eff_sub <= w_big[SIGN_BIT] ^ w_small[SIGN_BIT];
                    r_exp     <= w_big[EXP_MSB:EXP_LSB];
                    r_ma      <= w_big_m;
                    r_mb      <= w_small_m;
                    if (w_diff == '0) begin
                        r_state <= ADD;
                    end else begin
                        r_shift_cnt <= (w_diff > ALIGN_CAP) ? ALIGN_CAP : w_diff;
                        r_state     <= ALIGN;
                    end
                end

                ALIGN: begin
                    r_mb        <= {1'b0, r_mb[MW-1:2], r_mb[1] | r_mb[0]};
                    r_shift_cnt <= r_shift_cnt - EXP_ONE;
                    if (r_shift_cnt == EXP_ONE) begin
                        r_state <= ADD;
                    end
                end

                ADD: begin
                    r_sum   <= r_eff_sub ? ({1'b0, r_ma} - {1'b0, r_mb})
                                         : ({1'b0, r_ma} + {1'b0, r_mb});
                    r_state <= NORM;
                end

                NORM: begin
                    if (r_sum[MANT_W-1]) begin
                        r_sum   <= {1'b0, r_sum[MANT_W-1:2], r_sum[1] | r_sum[0]};
                        r_exp   <= r_exp + EXP_ONE;
                        r_state <= ROUND;
                    end else if (r_sum == '0) begin
                        r_result    <= '0;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else if (r_sum[MW-1]) begin
                        r_state <= ROUND;
                    end else if (r_exp <= EXP_ONE) begin
                        // Next shift would need a denormal exponent: flush.
                        r_result    <= {r_sign, {(DATA_WIDTH-1){1'b0}}};
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_sum <= {r_sum[MANT_W-2:0], 1'b0};
                        r_exp <= r_exp - EXP_ONE;
                    end
                end

                ROUND: begin
                    r_result    <= w_rounded;
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
                end

                DONE: begin
                    if (out_ready_in) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready_out  = r_in_ready;
    assign out_valid_out = r_out_valid;
    assign result_out    = r_result;
    assign busy_out      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fp_addsub_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_addsub_sequencer
// Brief    : Directed and randomized checks of fp_addsub_sequencer against an
//            exact-arithmetic reference model.
// Revision : 1.0
// ============================================================================
module tb_fp_addsub_sequencer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] floating1;
    logic [31:0] floating2;
    logic        opcode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;

    int n_compared   = 0;
    int n_mismatched = 0;

    fp_addsub_sequencer dut (
        .clk_in        (clk),
        .rst_n_in      (rst_n),
        .in_valid_in   (in_valid),
        .in_ready_out  (in_ready),
        .floating1_in  (floating1),
        .floating2_in  (floating2),
        .opcode_in     (opcode),
        .out_valid_out (out_valid),
        .out_ready_in  (out_ready),
        .result_out    (result),
        .busy_out      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Exact sum on a wide integer grid, then flush / RNE / overflow rules.
    function automatic logic [31:0] ref_addsub(input logic [31:0] fa, input logic [31:0] fb,
                                               input logic op);
        logic [31:0]  a, b;
        logic         sa, sb, sr, na, nb, ia, ib, up, found;
        int           ea, eb, emin, p, e, sh;
        logic [319:0] ma, mb, mag, keep, rem, half;
        a = fa;
        b = {fb[31] ^ op, fb[30:0]};
        if (a[30:23] == 8'd0) a = {a[31], 31'd0};
        if (b[30:23] == 8'd0) b = {b[31], 31'd0};
        sa = a[31];
        sb = b[31];
        na = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        nb = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        ia = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        ib = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        if (na || nb) return 32'h7FC00000;
        if (ia && ib) return (sa == sb) ? a : 32'h7FC00000;
        if (ia) return a;
        if (ib) return b;
        ea = (a[30:23] == 8'd0) ? 1 : int'(a[30:23]);
        eb = (b[30:23] == 8'd0) ? 1 : int'(b[30:23]);
        ma = (a[30:23] == 8'd0) ? 320'd0 : {296'd0, 1'b1, a[22:0]};
        mb = (b[30:23] == 8'd0) ? 320'd0 : {296'd0, 1'b1, b[22:0]};
        emin = (ea < eb) ? ea : eb;
        ma = ma << (ea - emin);
        mb = mb << (eb - emin);
        if (sa == sb) begin
            mag = ma + mb; sr = sa;
        end else if (ma >= mb) begin
            mag = ma - mb; sr = sa;
        end else begin
            mag = mb - ma; sr = sb;
        end
        if (mag == 320'd0) return 32'h0;
        p = 0;
        found = 1'b0;
        for (int i = 319; i >= 0; i--) begin
            if (!found && mag[i]) begin
                p = i;
                found = 1'b1;
            end
        end
        e = p + emin - 23;
        if (e <= 0) return {sr, 31'd0};
        if (p > 23) begin
            sh   = p - 23;
            keep = mag >> sh;
            rem  = mag & ((320'd1 << sh) - 320'd1);
            half = 320'd1 << (sh - 1);
            up   = (rem > half) || ((rem == half) && keep[0]);
            if (up) keep = keep + 320'd1;
        end else begin
            keep = mag << (23 - p);
        end
        if (keep[24]) begin
            keep = keep >> 1;
            e++;
        end
        if (e >= 255) return {sr, 8'hFF, 23'd0};
        return {sr, e[7:0], keep[22:0]};
    endfunction

    // One full request/response; lat counts edges with the accept edge as 1.
    task automatic run_op(input logic [31:0] fa, input logic [31:0] fb, input logic op,
                          input int hold, output logic [31:0] res, output int lat);
        int guard;
        bit ok;
        res = 32'h0;
        lat = -1;
        ok  = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        floating1 = fa;
        floating2 = fb;
        opcode    = op;
        in_valid  = 1'b1;
        guard = 0;
        while (!in_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            check_eq("accept_timeout", {31'd0, in_ready}, 32'd1);
            ok = 1'b0;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (ok) begin
            lat = 1;
            while (!out_valid && lat < 300) begin
                @(posedge clk);
                #1;
                lat++;
            end
            if (!out_valid) begin
                check_eq("valid_timeout", {31'd0, out_valid}, 32'd1);
                ok = 1'b0;
            end
        end
        if (ok) begin
            res = result;
            for (int k = 0; k < hold; k++) begin
                @(posedge clk);
                #1;
                check_eq("hold_valid",  {31'd0, out_valid}, 32'd1);
                check_eq("hold_result", result, res);
                check_eq("hold_ready",  {31'd0, in_ready}, 32'd0);
            end
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            check_eq("hs_clear", {31'd0, out_valid}, 32'd0);
        end
    endtask

    task automatic directed(input string tag, input logic [31:0] fa, input logic [31:0] fb,
                            input logic op, input logic [31:0] exp_res, input int exp_lat);
        logic [31:0] res;
        int          lat;
        run_op(fa, fb, op, 0, res, lat);
        check_eq(tag, res, exp_res);
        if (exp_lat > 0) check_eq({tag, "_lat"}, lat, exp_lat);
    endtask

    logic [31:0] specials [10];

    initial begin
        logic [31:0] ra, rb, res, held;
        logic        rop;
        int          lat, kind, ea, eb, hold, guard;
        bit          seen;

        specials = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000, 32'h7FC00000,
                     32'h7F800001, 32'h00000001, 32'h7F7FFFFF, 32'h00800000, 32'h3F800000};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        floating1 = 32'h0;
        floating2 = 32'h0;
        opcode    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_result",    result, 32'd0);
        check_eq("rst_busy",      {31'd0, busy},      32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        directed("one_plus_one",   32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 6);
        directed("align_diff2",    32'h3FC00000, 32'h3E800000, 1'b0, 32'h3FE00000, 8);
        directed("cancel_zero",    32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, -1);
        directed("tie_even",       32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 30);
        directed("tie_odd_up",     32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, -1);
        directed("inf_minus_inf",  32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 2);
        directed("max_overflow",   32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 6);
        directed("nan_in",         32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 2);
        directed("neg_inf",        32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 2);
        directed("denorm_flush",   32'h00400000, 32'h3F800000, 1'b0, 32'h3F800000, -1);
        directed("norm_one_shift", 32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000, 8);
        directed("underflow",      32'h00800000, 32'h00800001, 1'b1, 32'h80000000, -1);

        // Backpressure with a second request waiting.
        @(negedge clk);
        floating1 = 32'h3F800000;
        floating2 = 32'h3F800000;
        opcode    = 1'b0;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        guard = 0;
        while (!out_valid && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check_eq("bp_valid", {31'd0, out_valid}, 32'd1);
        held = result;
        check_eq("bp_result", held, 32'h40000000);
        floating1 = 32'h3FC00000;
        floating2 = 32'h3E800000;
        in_valid  = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            check_eq("bp_hold_valid",  {31'd0, out_valid}, 32'd1);
            check_eq("bp_hold_result", result, held);
            check_eq("bp_hold_ready",  {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq("bp_hs_valid", {31'd0, out_valid}, 32'd0);
        check_eq("bp_hs_ready", {31'd0, in_ready},  32'd1);
        check_eq("bp_hs_busy",  {31'd0, busy},      32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_eq("bp_second_busy",  {31'd0, busy},     32'd1);
        check_eq("bp_second_ready", {31'd0, in_ready}, 32'd0);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq("bp_second_result", result, 32'h3FE00000);
        check_eq("bp_second_lat", lat, 8);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Reset while the smaller operand is still being aligned.
        @(negedge clk);
        floating1 = 32'h4B000000;
        floating2 = 32'h3F800000;
        opcode    = 1'b0;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_eq("pre_rst_busy", {31'd0, busy}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_in_ready",  {31'd0, in_ready},  32'd1);
        check_eq("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("mid_rst_result",    result, 32'd0);
        check_eq("mid_rst_busy",      {31'd0, busy},      32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check_eq("rst_no_valid", {31'd0, seen}, 32'd0);
        directed("after_rst", 32'h4B000000, 32'h3F800000, 1'b0, 32'h4B000001, 29);

        for (int i = 0; i < 300; i++) begin
            kind = int'($urandom_range(0, 9));
            rop  = 1'($urandom_range(0, 1));
            ea   = int'($urandom_range(1, 254));
            eb   = ea + int'($urandom_range(0, 64)) - 32;
            if (kind == 3) ea = int'($urandom_range(248, 254));
            if (kind == 4) ea = int'($urandom_range(1, 6));
            if (kind == 3 || kind == 4) eb = ea + int'($urandom_range(0, 4)) - 2;
            if (eb < 0)   eb = 0;
            if (eb > 255) eb = 255;
            ra = {1'($urandom_range(0, 1)), ea[7:0], 23'($urandom())};
            rb = {1'($urandom_range(0, 1)), eb[7:0], 23'($urandom())};
            if (kind == 0) begin
                ra = $urandom();
                rb = $urandom();
            end else if (kind == 1) begin
                ra = specials[$urandom_range(0, 9)];
                if ($urandom_range(0, 1) == 0) rb = specials[$urandom_range(0, 9)];
            end else if (kind == 2) begin
                rb = {ra[31] ^ rop, ra[30:23], ra[22:0] ^ 23'($urandom_range(0, 255))};
            end
            hold = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 4)) : 0;
            run_op(ra, rb, rop, hold, res, lat);
            check_eq($sformatf("rand%0d %08h %s %08h", i, ra, rop ? "-" : "+", rb),
                     res, ref_addsub(ra, rb, rop));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/fp_addsub_sequencer.md
Name: fp_addsub_sequencer

Overview:
Multi-cycle single-precision IEEE-754 add/subtract unit with a valid/ready front end and a valid/ready result port. An FSM steps one operation through exponent compare, alignment, mantissa add, normalization and rounding, using iterative one-bit shifters and a cycle counter. It is the sequenced, area-lean alternative to the combinational adder chain. It sits between an issuing core and any consumer of the result.

Parameters:
DATA_WIDTH, 32, operand/result width
MENT_WIDTH, 23, stored mantissa bits
EXPO_WIDTH, 8, exponent bits
MAX_ALIGN, 26, alignment shifts beyond which the smaller operand collapses into sticky only

Ports:
clk_in  input  1  clock, rising edge
rst_n_in  input  1  asynchronous active-low reset
in_valid_in  input  1  operand request valid
in_ready_out  output  1  unit can accept a request
floating1_in  input  32  operand A
floating2_in  input  32  operand B
opcode_in  input  1  0 = A+B, 1 = A-B
out_valid_out  output  1  result valid
out_ready_in  input  1  consumer accepts result
result_out  output  32  IEEE-754 result
busy_out  output  1  FSM not in IDLE

Behaviour:
- Reset (async, rst_n_in low): state=IDLE; in_ready_out=1; out_valid_out=0; result_out=0; busy_out=0. All internal registers clear. Reset mid-operation abandons the operation; no result is produced.
- Accept: in IDLE, in_ready_out=1. On in_valid_in&&in_ready_out at a rising edge, the unit captures both operands and the opcode. opcode=1 inverts B's sign. The FSM then goes to CHECK. in_ready_out=0 in every state other than IDLE.
- CHECK:
  - An exponent of 0 flushes that operand to signed zero (no denormals).
  - Any NaN, or inf+(-inf) after the sign flip, gives 0x7FC00000.
  - A single inf, or two infs of the same sign, gives that inf.
  - Special-case results go straight to DONE. Otherwise the FSM goes to COMPARE.
- COMPARE:
  - Swap so that A has the larger magnitude (exponent first, then mantissa).
  - diff = expA - expB, unsigned 8-bit.
  - Mantissas become 27-bit {hidden, 23 frac, G, R, S}.
  - diff=0 goes to ADD. Otherwise shift_cnt=min(diff, MAX_ALIGN+1) and the FSM goes to ALIGN.
- ALIGN: shift B right by one bit per cycle. S is ORed with each bit shifted out. Decrement shift_cnt and go to ADD when it reaches 1→0.
- ADD: 28-bit add when signs are equal, subtract (A-B) when they differ. The result sign is A's sign.
- NORM:
  - Carry set: shift right 1 with sticky OR, exp+1. One cycle.
  - Zero result: +0 (0x00000000), then DONE.
  - Otherwise shift left 1 per cycle, exp-1, until the hidden bit is 1.
  - If exp reaches 0 during left shifts, flush to signed zero and go to DONE.
- ROUND:
  - Round to nearest even: increment when G&&(R||S||lsb).
  - Mantissa overflow: shift right, exp+1.
  - exp==255 gives signed inf.
  - Pack the result and go to DONE.
- DONE:
  - out_valid_out=1 and result_out holds its value until out_valid_out&&out_ready_in.
  - On that handshake: out_valid_out=0, state=IDLE, in_ready_out=1 on the next cycle.
  - No new request is accepted in the handshake cycle itself.
- Latency, counted in edges from the accept edge to out_valid_out high:
  - Normal path with diff=0 and a one-step normalization: 6 edges.
  - Add min(diff, 27) for ALIGN.
  - Add one per extra left-normalize shift.
  - Special cases: 2 edges.
- busy_out = (state != IDLE).

Decomposition:
- Package fp_addsub_pkg holds:
  - the state enum (IDLE, CHECK, COMPARE, ALIGN, ADD, NORM, ROUND, DONE)
  - QNAN=32'h7FC00000, EXP_MAX=8'hFF
  - the mantissa working width constant (28)
- One sub-module, fp_round_rne: combinational rounding and packing of the sign, exponent and 27-bit mantissa. The FSM, shifters and counters stay in the top module.

Test Plan:
- 0x3F800000 + 0x3F800000, op=0 -> 0x40000000. out_valid_out high 6 edges after accept (carry path).
- 0x3FC00000 + 0x3E800000 (1.5+0.25) -> 0x3FE00000. Latency 8 (diff=2).
- 0x3F800000 - 0x3F800000, op=1 -> 0x00000000. Then 0x3F800000 + 0x33800000 -> 0x3F800000 (tie, even). Then 0x3F800001 + 0x33800000 -> 0x3F800002.
- 0x7F800000 - 0x7F800000 -> 0x7FC00000 in 2 edges. 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000.
- Backpressure: out_ready_in low for 10 cycles. result_out and out_valid_out stay stable, in_ready_out stays 0, and a second in_valid_in is not accepted until the cycle after the handshake.
- Reset mid-operation: pull rst_n_in low during ALIGN. Outputs go to reset values immediately, no out_valid_out appears, and the next request completes correctly.
